// File: rtl/keypad_scanner_if.sv
// Keypad/display side bundle of keypad_scanner: row/column lines, clear, key report, digit register.
// master = scanner, slave = keypad/display side.
interface keypad_scanner_if;
    logic [3:0]  col;
    logic        clr;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [31:0] dig;

    modport master (
        input  col,
        input  clr,
        output row,
        output key_code,
        output key_valid,
        output dig
    );

    modport slave (
        output col,
        output clr,
        input  row,
        input  key_code,
        input  key_valid,
        input  dig
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks active-low rows, debounces press/release, shifts accepted codes into dig.
// Latency: 2-cycle col sync plus DEBOUNCE scan ticks to accept; key_valid is a one-cycle pulse.
// No backpressure: a press is reported once; clr always overrides the dig update.
module keypad_scanner #(
    parameter int DIV      = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic               clkx,
    input  logic               rst_n,
    keypad_scanner_if.master   bus
);
    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE);

    typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HOLD, ST_RELEASE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  col_s1_q, col_s1_d;
    logic [3:0]  col_s_q, col_s_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]  r_q, r_d;
    logic [3:0]  pat_q, pat_d;
    logic [1:0]  c_q, c_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]  key_code_q, key_code_d;
    logic        key_valid_q, key_valid_d;
    logic [31:0] dig_q, dig_d;

    logic          tick;
    logic          accept;
    logic [1:0]    low_idx;
    logic [CW-1:0] cnt_inc;

    always_comb begin
        col_s1_d    = bus.col;
        col_s_d     = col_s1_q;
        tick        = (pre_q == PMAX);
        pre_d       = tick ? '0 : pre_q + 1'b1;
        cnt_inc     = cnt_q + 1'b1;

        // Lowest low column wins when several are pressed together.
        if (!col_s_q[0])      low_idx = 2'd0;
        else if (!col_s_q[1]) low_idx = 2'd1;
        else if (!col_s_q[2]) low_idx = 2'd2;
        else                  low_idx = 2'd3;

        state_d     = state_q;
        r_d         = r_q;
        pat_d       = pat_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        accept      = 1'b0;

        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (col_s_q == 4'hF) begin
                        r_d = r_q + 1'b1;
                    end else begin
                        pat_d   = col_s_q;
                        c_d     = low_idx;
                        cnt_d   = '0;
                        state_d = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (col_s_q != pat_q) begin
                        state_d = ST_SCAN;
                    end else if (cnt_inc == CMAX) begin
                        cnt_d   = cnt_inc;
                        state_d = ST_HOLD;
                        accept  = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_HOLD: begin
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (col_s_q != 4'hF) begin
                        cnt_d = '0;
                    end else if (cnt_inc == CMAX) begin
                        cnt_d   = '0;
                        r_d     = r_q + 1'b1;
                        state_d = ST_SCAN;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end

        if (accept) begin
            key_code_d  = {r_q, c_q};
            key_valid_d = 1'b1;
        end

        if (bus.clr)     dig_d = '0;
        else if (accept) dig_d = {dig_q[27:0], r_q, c_q};
        else             dig_d = dig_q;
    end

    always_ff @(posedge clkx or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SCAN;
            col_s1_q    <= 4'hF;
            col_s_q     <= 4'hF;
            pre_q       <= '0;
            r_q         <= '0;
            pat_q       <= 4'hF;
            c_q         <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            dig_q       <= '0;
        end else begin
            state_q     <= state_d;
            col_s1_q    <= col_s1_d;
            col_s_q     <= col_s_d;
            pre_q       <= pre_d;
            r_q         <= r_d;
            pat_q       <= pat_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            dig_q       <= dig_d;
        end
    end

    assign bus.row       = ~(4'b0001 << r_q);
    assign bus.key_code  = key_code_q;
    assign bus.key_valid = key_valid_q;
    assign bus.dig       = dig_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (DIV=4, DEBOUNCE=3); a keypad model resolves col from row.
module tb_keypad_scanner;
    logic clkx = 1'b0;
    logic rst_n;
    always #5 clkx = ~clkx;

    keypad_scanner_if kif();

    keypad_scanner #(.DIV(4), .DEBOUNCE(3)) dut (
        .clkx  (clkx),
        .rst_n (rst_n),
        .bus   (kif)
    );

    logic       pressed;
    logic [1:0] prow;
    logic [1:0] pcol;

    assign kif.col = (pressed && kif.row[prow] == 1'b0) ? ~(4'b0001 << pcol) : 4'hF;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Advance n negedges, counting cycles where key_valid is high.
    task automatic step(input int n, inout int pulses);
        repeat (n) begin
            @(negedge clkx);
            if (kif.key_valid) pulses++;
        end
    endtask

    // Return just after the row drive switches to pat (a tick edge).
    task automatic wait_row(input logic [3:0] pat);
        int n = 0;
        while (kif.row == pat && n < 100) begin @(negedge clkx); n++; end
        while (kif.row != pat && n < 100) begin @(negedge clkx); n++; end
        chk("row_sync", {28'h0, kif.row}, {28'h0, pat});
    endtask

    task automatic press_key(input logic [3:0] code, input int hold, output int pulses);
        pulses  = 0;
        prow    = code[3:2];
        pcol    = code[1:0];
        pressed = 1'b1;
        step(hold, pulses);
        pressed = 1'b0;
        step(40, pulses);
    endtask

    logic [3:0] row_seq [5];
    int pulses;
    int total;

    initial begin
        row_seq[0] = 4'b1110; row_seq[1] = 4'b1101; row_seq[2] = 4'b1011;
        row_seq[3] = 4'b0111; row_seq[4] = 4'b1110;
        rst_n   = 1'b0;
        pressed = 1'b0;
        prow    = 2'd0;
        pcol    = 2'd0;
        kif.clr = 1'b0;
        repeat (3) @(negedge clkx);
        chk("rst_row", {28'h0, kif.row}, 32'h0000000E);
        chk("rst_code", {28'h0, kif.key_code}, 32'h0);
        chk("rst_valid", {31'h0, kif.key_valid}, 32'h0);
        chk("rst_dig", kif.dig, 32'h0);

        // Idle scan: row advances every 4 clkx.
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clkx);
            if (kif.key_valid) pulses++;
            if (i % 4 == 2 && i <= 18)
                chk($sformatf("idle_row%0d", i / 4), {28'h0, kif.row}, {28'h0, row_seq[i / 4]});
        end
        chk("idle_pulses", pulses, 0);
        chk("idle_dig", kif.dig, 32'h0);

        // Row 2 / col 1 held for 30 ticks.
        press_key(4'h9, 120, pulses);
        chk("k9_pulses", pulses, 1);
        chk("k9_code", {28'h0, kif.key_code}, 32'h9);
        chk("k9_dig", kif.dig, 32'h00000009);

        // Nine keys 1..9: oldest digits fall off the top.
        total = 0;
        for (int k = 1; k <= 9; k++) begin
            press_key(4'(k), 60, pulses);
            total += pulses;
        end
        chk("seq_pulses", total, 9);
        chk("seq_dig", kif.dig, 32'h23456789);
        chk("seq_code", {28'h0, kif.key_code}, 32'h9);

        // Bounce on row 1: two aborted debounces, r must not move.
        pulses = 0;
        wait_row(4'b1101);
        prow = 2'd1; pcol = 2'd2;
        pressed = 1'b1; step(4, pulses);
        pressed = 1'b0; step(4, pulses);
        pressed = 1'b1; step(4, pulses);
        pressed = 1'b0; step(4, pulses);
        chk("bounce_row_hold", {28'h0, kif.row}, 32'h0000000D);
        step(4, pulses);
        chk("bounce_row_next", {28'h0, kif.row}, 32'h0000000B);
        step(20, pulses);
        chk("bounce_pulses", pulses, 0);
        chk("bounce_dig", kif.dig, 32'h23456789);

        // clr on the same edge as the accept of key 5.
        pulses = 0;
        wait_row(4'b1101);
        prow = 2'd1; pcol = 2'd1;
        pressed = 1'b1;
        repeat (15) @(negedge clkx);
        kif.clr = 1'b1;
        @(negedge clkx);
        kif.clr = 1'b0;
        chk("clr_valid", {31'h0, kif.key_valid}, 32'h1);
        chk("clr_code", {28'h0, kif.key_code}, 32'h5);
        chk("clr_dig", kif.dig, 32'h0);
        step(20, pulses);
        pressed = 1'b0;
        step(40, pulses);
        chk("clr_extra_pulses", pulses, 0);

        // Asynchronous reset while debouncing row 1 / col 2.
        pulses = 0;
        wait_row(4'b1101);
        prow = 2'd1; pcol = 2'd2;
        pressed = 1'b1;
        repeat (6) @(negedge clkx);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_row", {28'h0, kif.row}, 32'h0000000E);
        chk("arst_code", {28'h0, kif.key_code}, 32'h0);
        chk("arst_valid", {31'h0, kif.key_valid}, 32'h0);
        chk("arst_dig", kif.dig, 32'h0);
        pressed = 1'b0;
        @(negedge clkx);
        rst_n = 1'b1;
        step(2, pulses);
        chk("arst_resume_row", {28'h0, kif.row}, 32'h0000000E);
        step(60, pulses);
        chk("arst_pulses", pulses, 0);
        chk("arst_code_after", {28'h0, kif.key_code}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
